capture_ctrl: RTL and testbench

//  Sequences one logic-analyzer capture into the circular sample RAM.
//  - Starts on a host run pulse and advances the write address on every decimated sample strobe.
//  - Asserts armed to the trigger logic once enough pre-trigger samples are held.
//  - After triggered, counts trig_pos post-trigger samples, then pulses set_capture_done
//    and holds capture_done until the host acknowledges.

---
 rtl/cap_pkg.sv | 14 +
 rtl/cap_addr_ctr.sv | 26 ++
 rtl/capture_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_capture_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cap_pkg.sv
// Shared types and default sizing for the capture controller slice.
package cap_pkg;

    localparam int unsigned CAP_ENTRIES = 384;
    localparam int unsigned CAP_AW      = 9;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/cap_addr_ctr.sv
// Circular write-address counter for the sample RAM; wraps ENTRIES-1 -> 0.
module cap_addr_ctr
    import cap_pkg::*;
#(
    parameter int unsigned ENTRIES = CAP_ENTRIES,
    parameter int unsigned AW      = CAP_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] addr
);

    // Clear wins over increment so a restart always begins at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= (addr == AW'(ENTRIES - 1)) ? '0 : addr + AW'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Sequences one logic-analyzer capture: pre-trigger fill, post-trigger count, done handshake.
// Define CAPTURE_TIMEOUT_EN to add the armed-sample watchdog and the timeout output.
module capture_ctrl
    import cap_pkg::*;
#(
    parameter int unsigned ENTRIES   = CAP_ENTRIES,
    parameter int unsigned AW        = CAP_AW
`ifdef CAPTURE_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          wrt_smpl,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    input  logic          cap_ack,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          set_capture_done,
    output logic          capture_done,
    output logic [AW-1:0] trace_end
`ifdef CAPTURE_TIMEOUT_EN
   ,output logic          timeout
`endif
);

    localparam int unsigned CW = AW + 1;

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic [CW-1:0] smpl_cnt;
    logic [CW-1:0] smpl_cnt_nxt;
    logic [CW-1:0] smpl_cnt_adv;
    logic [CW-1:0] fill_sum;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] post_cnt_nxt;
    logic [AW-1:0] post_cnt_inc;
    logic [AW-1:0] tp;
    logic [AW-1:0] waddr_prev;
    logic [AW-1:0] trace_end_nxt;
    logic          armed_nxt;
    logic          capture_done_nxt;
    logic          set_capture_done_nxt;
    logic          addr_clr;
    logic          complete;
    logic          to_hit;

`ifdef CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [TIMEOUT_W-1:0] to_cnt_nxt;
    logic                 timeout_nxt;
`endif

    // Post-trigger depth can never exceed one RAM less the trigger sample itself.
    assign tp = (CW'(trig_pos) >= CW'(ENTRIES)) ? AW'(ENTRIES - 1) : trig_pos;

    assign waddr_prev   = (waddr == '0) ? AW'(ENTRIES - 1) : waddr - AW'(1);
    assign post_cnt_inc = post_cnt + AW'(1);
    assign smpl_cnt_adv = (wrt_smpl && (smpl_cnt != CW'(ENTRIES))) ? smpl_cnt + CW'(1) : smpl_cnt;
    assign fill_sum     = smpl_cnt_adv + CW'(tp);

    cap_addr_ctr #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_addr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (addr_clr),
        .inc   (we),
        .addr  (waddr)
    );

    // Next-state, counter and flag updates.
    always_comb begin
        state_nxt            = state;
        smpl_cnt_nxt         = smpl_cnt;
        post_cnt_nxt         = post_cnt;
        armed_nxt            = armed;
        capture_done_nxt     = capture_done;
        set_capture_done_nxt = 1'b0;
        trace_end_nxt        = trace_end;
        we                   = 1'b0;
        addr_clr             = 1'b0;
        complete             = 1'b0;
        to_hit               = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        to_cnt_nxt           = to_cnt;
        timeout_nxt          = timeout;
`endif

        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nxt    = PRE;
                    addr_clr     = 1'b1;
                    smpl_cnt_nxt = '0;
                    post_cnt_nxt = '0;
`ifdef CAPTURE_TIMEOUT_EN
                    to_cnt_nxt   = '0;
`endif
                end
            end

            PRE: begin
                we           = wrt_smpl;
                smpl_cnt_nxt = smpl_cnt_adv;
                if (fill_sum >= CW'(ENTRIES)) begin
                    armed_nxt = 1'b1;
                end
`ifdef CAPTURE_TIMEOUT_EN
                if (armed && wrt_smpl) begin
                    to_cnt_nxt = to_cnt + TIMEOUT_W'(1);
                end
                to_hit = &to_cnt_nxt;
`endif
                // A strobe in the transition cycle is written as a pre-trigger sample.
                if (to_hit) begin
                    complete = 1'b1;
                end else if (triggered && armed) begin
                    state_nxt = POST;
                end
            end

            POST: begin
                if (tp == '0) begin
                    complete = 1'b1;
                end else begin
                    we = wrt_smpl;
                    if (wrt_smpl) begin
                        post_cnt_nxt = post_cnt_inc;
                        if (post_cnt_inc == tp) begin
                            complete = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                if (cap_ack) begin
                    state_nxt        = IDLE;
                    capture_done_nxt = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
                    timeout_nxt      = 1'b0;
`endif
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Trace end is the address written this cycle, else the last one written.
        if (complete) begin
            state_nxt            = DONE;
            set_capture_done_nxt = 1'b1;
            capture_done_nxt     = 1'b1;
            armed_nxt            = 1'b0;
            trace_end_nxt        = we ? waddr : waddr_prev;
`ifdef CAPTURE_TIMEOUT_EN
            if (to_hit) begin
                timeout_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            smpl_cnt         <= '0;
            post_cnt         <= '0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
            capture_done     <= 1'b0;
            trace_end        <= '0;
`ifdef CAPTURE_TIMEOUT_EN
            to_cnt           <= '0;
            timeout          <= 1'b0;
`endif
        end else begin
            state            <= state_nxt;
            smpl_cnt         <= smpl_cnt_nxt;
            post_cnt         <= post_cnt_nxt;
            armed            <= armed_nxt;
            set_capture_done <= set_capture_done_nxt;
            capture_done     <= capture_done_nxt;
            trace_end        <= trace_end_nxt;
`ifdef CAPTURE_TIMEOUT_EN
            to_cnt           <= to_cnt_nxt;
            timeout          <= timeout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus randomized captures against a count-level model.
module tb_capture_ctrl;
    import cap_pkg::*;

    localparam int E  = CAP_ENTRIES;
    localparam int AW = CAP_AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          wrt_smpl;
    logic          triggered;
    logic [AW-1:0] trig_pos;
    logic          cap_ack;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          set_capture_done;
    logic          capture_done;
    logic [AW-1:0] trace_end;
`ifdef CAPTURE_TIMEOUT_EN
    logic          timeout;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model: capture phase (0 idle, 1 pre, 2 post, 3 done) plus sample counts.
    int m_phase, m_addr, m_pre, m_post, m_trace, tpc;
    bit m_armed, m_cd, m_scd, m_we;

    capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .wrt_smpl         (wrt_smpl),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .cap_ack          (cap_ack),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .capture_done     (capture_done),
        .trace_end        (trace_end)
`ifdef CAPTURE_TIMEOUT_EN
       ,.timeout          (timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_phase = 0; m_addr = 0; m_pre = 0; m_post = 0; m_trace = 0;
        m_armed = 0; m_cd = 0; m_scd = 0; m_we = 0;
    endfunction

    function automatic void model_edge();
        bit arm_was;
        m_scd = 0;
        case (m_phase)
            0: if (run) begin m_phase = 1; m_addr = 0; m_pre = 0; m_post = 0; end
            1: begin
                arm_was = m_armed;
                if (wrt_smpl) begin m_addr = (m_addr + 1) % E; m_pre++; end
                if (((m_pre < E) ? m_pre : E) + tpc >= E) m_armed = 1;
                if (triggered && arm_was) m_phase = 2;
            end
            2: begin
                if (tpc != 0 && wrt_smpl) begin m_addr = (m_addr + 1) % E; m_post++; end
                if (m_post == tpc) begin
                    m_trace = (m_addr + E - 1) % E;
                    m_cd = 1; m_armed = 0; m_scd = 1; m_phase = 3;
                end
            end
            3: if (cap_ack) begin m_cd = 0; m_phase = 0; end
            default: m_phase = 0;
        endcase
    endfunction

    task automatic set_in(input logic r, input logic w, input logic t, input logic a);
        run = r; wrt_smpl = w; triggered = t; cap_ack = a;
        m_we = (m_phase == 1 && w) || (m_phase == 2 && tpc != 0 && w);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_tp(input int v);
        trig_pos = AW'(v);
        tpc = (v >= E) ? E - 1 : v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_strobes(input int n, input logic t);
        for (int i = 0; i < n; i++) begin
            set_in(0, 1, t, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_tp(0);
        run = 0; wrt_smpl = 0; triggered = 0; cap_ack = 0;
        model_reset();
        #3;
        total++; if (waddr !== '0) $display("FAIL reset_waddr got=%0d exp=0", waddr); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL reset_armed got=%b exp=0", armed); else passed++;
        total++; if (set_capture_done !== 1'b0) $display("FAIL reset_scd got=%b exp=0", set_capture_done); else passed++;
        total++; if (capture_done !== 1'b0) $display("FAIL reset_cd got=%b exp=0", capture_done); else passed++;
        total++; if (trace_end !== '0) $display("FAIL reset_trace_end got=%0d exp=0", trace_end); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(0, 1, 0, 0);
        total++; if (we !== 1'b0) $display("FAIL idle_we got=%b exp=0", we); else passed++;
        tick();
        total++; if (waddr !== '0) $display("FAIL idle_waddr got=%0d exp=0", waddr); else passed++;
    endtask

    task automatic test_fill_wrap();
        int first_arm = 0;
        int we_bad = 0;
        logic [AW-1:0] addr383 = '0;
        do_reset();
        set_tp(100);
        set_in(1, 0, 0, 0);
        tick();
        for (int i = 1; i <= E; i++) begin
            set_in(0, 1, 0, 0);
            if (we !== 1'b1) we_bad++;
            tick();
            if (armed === 1'b1 && first_arm == 0) first_arm = i;
            if (i == E - 1) addr383 = waddr;
        end
        total++; if (we_bad != 0) $display("FAIL pre_we_missing got=%0d exp=0", we_bad); else passed++;
        total++; if (first_arm != 284) $display("FAIL armed_rise_sample got=%0d exp=284", first_arm); else passed++;
        total++; if (addr383 !== AW'(383)) $display("FAIL waddr_before_wrap got=%0d exp=383", addr383); else passed++;
        total++; if (waddr !== '0) $display("FAIL waddr_wrap got=%0d exp=0", waddr); else passed++;
        total++; if (armed !== 1'b1) $display("FAIL armed_hold got=%b exp=1", armed); else passed++;
    endtask

    // Continues from the armed PRE state left by test_fill_wrap.
    task automatic test_post_count();
        int strobes = 0;
        int early = 0;
        int we_bad = 0;
        logic w;
        set_in(0, 0, 1, 0);
        tick();
        for (int i = 0; strobes < 100 && i < 2000; i++) begin
            w = ($urandom_range(0, 2) != 0);
            set_in(0, w, 0, 0);
            if (we !== w) we_bad++;
            tick();
            if (w) strobes++;
            if (strobes < 100 && (set_capture_done === 1'b1 || capture_done === 1'b1)) early++;
        end
        total++; if (we_bad != 0) $display("FAIL post_we got=%0d bad exp=0", we_bad); else passed++;
        total++; if (early != 0) $display("FAIL post_early_done got=%0d exp=0", early); else passed++;
        total++; if (set_capture_done !== 1'b1) $display("FAIL post_scd got=%b exp=1", set_capture_done); else passed++;
        total++; if (capture_done !== 1'b1) $display("FAIL post_cd got=%b exp=1", capture_done); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL post_armed_clr got=%b exp=0", armed); else passed++;
        total++; if (waddr !== AW'(100)) $display("FAIL post_waddr got=%0d exp=100", waddr); else passed++;
        total++; if (trace_end !== AW'(99)) $display("FAIL post_trace_end got=%0d exp=99", trace_end); else passed++;
        set_in(0, 0, 0, 0);
        tick();
        total++; if (set_capture_done !== 1'b0) $display("FAIL scd_one_cycle got=%b exp=0", set_capture_done); else passed++;
    endtask

    // Continues from the DONE state left by test_post_count.
    task automatic test_done_ack();
        set_in(1, 1, 0, 0);
        total++; if (we !== 1'b0) $display("FAIL done_we got=%b exp=0", we); else passed++;
        tick();
        total++; if (waddr !== AW'(100)) $display("FAIL done_waddr got=%0d exp=100", waddr); else passed++;
        total++; if (capture_done !== 1'b1) $display("FAIL done_cd_hold got=%b exp=1", capture_done); else passed++;
        set_in(0, 0, 0, 1);
        tick();
        total++; if (capture_done !== 1'b0) $display("FAIL ack_cd got=%b exp=0", capture_done); else passed++;
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0);
        total++; if (we !== 1'b1) $display("FAIL rerun_we got=%b exp=1", we); else passed++;
        tick();
        total++; if (waddr !== AW'(1)) $display("FAIL rerun_waddr got=%0d exp=1", waddr); else passed++;
    endtask

    task automatic test_trig_pos_zero();
        do_reset();
        set_tp(0);
        set_in(1, 0, 0, 0);
        tick();
        run_strobes(E + 5, 1'b0);
        total++; if (armed !== 1'b1) $display("FAIL tp0_armed got=%b exp=1", armed); else passed++;
        set_in(0, 1, 1, 0);
        tick();
        total++; if (waddr !== AW'(6)) $display("FAIL tp0_entry_write got=%0d exp=6", waddr); else passed++;
        total++; if (set_capture_done !== 1'b0) $display("FAIL tp0_scd_early got=%b exp=0", set_capture_done); else passed++;
        set_in(0, 1, 0, 0);
        total++; if (we !== 1'b0) $display("FAIL tp0_post_we got=%b exp=0", we); else passed++;
        tick();
        total++; if (set_capture_done !== 1'b1) $display("FAIL tp0_scd got=%b exp=1", set_capture_done); else passed++;
        total++; if (trace_end !== AW'(5)) $display("FAIL tp0_trace_end got=%0d exp=5", trace_end); else passed++;
        total++; if (waddr !== AW'(6)) $display("FAIL tp0_waddr got=%0d exp=6", waddr); else passed++;
    endtask

    task automatic test_early_trigger();
        do_reset();
        set_tp(100);
        set_in(1, 0, 0, 0);
        tick();
        run_strobes(10, 1'b1);
        total++; if (armed !== 1'b0) $display("FAIL early_armed got=%b exp=0", armed); else passed++;
        total++; if (waddr !== AW'(10)) $display("FAIL early_waddr got=%0d exp=10", waddr); else passed++;
        run_strobes(274, 1'b0);
        total++; if (armed !== 1'b1) $display("FAIL early_armed_late got=%b exp=1", armed); else passed++;
        total++; if (capture_done !== 1'b0) $display("FAIL early_cd got=%b exp=0", capture_done); else passed++;
        set_in(0, 0, 1, 0);
        tick();
        run_strobes(99, 1'b0);
        total++; if (capture_done !== 1'b0) $display("FAIL early_cd_99 got=%b exp=0", capture_done); else passed++;
        run_strobes(1, 1'b0);
        total++; if (set_capture_done !== 1'b1) $display("FAIL early_scd got=%b exp=1", set_capture_done); else passed++;
        total++; if (trace_end !== AW'(383)) $display("FAIL early_trace_end got=%0d exp=383", trace_end); else passed++;
        total++; if (waddr !== '0) $display("FAIL early_final_waddr got=%0d exp=0", waddr); else passed++;
    endtask

    task automatic test_reset_mid_post();
        do_reset();
        set_tp(5);
        set_in(1, 0, 0, 0);
        tick();
        run_strobes(379, 1'b0);
        total++; if (armed !== 1'b1) $display("FAIL midrst_armed got=%b exp=1", armed); else passed++;
        set_in(0, 0, 1, 0);
        tick();
        run_strobes(3, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (waddr !== '0) $display("FAIL midrst_waddr got=%0d exp=0", waddr); else passed++;
        total++; if (armed !== 1'b0) $display("FAIL midrst_armed_clr got=%b exp=0", armed); else passed++;
        set_in(0, 1, 0, 0);
        @(posedge clk);
        #1;
        total++; if (set_capture_done !== 1'b0) $display("FAIL midrst_scd got=%b exp=0", set_capture_done); else passed++;
        total++; if (capture_done !== 1'b0) $display("FAIL midrst_cd got=%b exp=0", capture_done); else passed++;
        rst_n = 1'b1;
        run_strobes(3, 1'b0);
        total++; if (waddr !== '0) $display("FAIL midrst_idle_waddr got=%0d exp=0", waddr); else passed++;
        total++; if (set_capture_done !== 1'b0) $display("FAIL midrst_idle_scd got=%b exp=0", set_capture_done); else passed++;
    endtask

    task automatic test_random();
        logic r, w, t, a;
        do_reset();
        set_tp(0);
        for (int cyc = 0; cyc < 15000; cyc++) begin
            r = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 9) < 7);
            t = ($urandom_range(0, 15) == 0);
            a = (m_phase == 3) && ($urandom_range(0, 3) == 0);
            if (m_phase == 0 && r) set_tp($urandom_range(0, 511));
            set_in(r, w, t, a);
            total++; if (we !== m_we) $display("FAIL rand_we cyc=%0d got=%b exp=%b", cyc, we, m_we); else passed++;
            tick();
            total++; if (waddr !== AW'(m_addr)) $display("FAIL rand_waddr cyc=%0d got=%0d exp=%0d", cyc, waddr, m_addr); else passed++;
            total++; if (armed !== m_armed) $display("FAIL rand_armed cyc=%0d got=%b exp=%b", cyc, armed, m_armed); else passed++;
            total++; if (set_capture_done !== m_scd) $display("FAIL rand_scd cyc=%0d got=%b exp=%b", cyc, set_capture_done, m_scd); else passed++;
            total++; if (capture_done !== m_cd) $display("FAIL rand_cd cyc=%0d got=%b exp=%b", cyc, capture_done, m_cd); else passed++;
            total++; if (trace_end !== AW'(m_trace)) $display("FAIL rand_trace_end cyc=%0d got=%0d exp=%0d", cyc, trace_end, m_trace); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_post_count();
        test_done_ack();
        test_trig_pos_zero();
        test_early_trigger();
        test_reset_mid_post();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
